dram_arb_ctrl: RTL

DRAM_ARB_CTRL -- requirements
Module: dram_arb_ctrl

---
 rtl/dram_arb_ctrl_if.sv | 26 ++
 rtl/dram_arb_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dram_arb_ctrl_if.sv
// Requester-side handshake bundle for the DRAM arbiter: one write port and one read port.
interface dram_arb_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    // Requester side drives requests and consumes completions
    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ack, rd_data, rd_valid
    );

    // Arbiter side consumes requests and drives completions
    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ack, rd_data, rd_valid
    );
endinterface

// File: rtl/dram_arb_ctrl.sv
// Arbitrates one write and one read requester onto a simple SRAM/DRAM-style
// memory port. Writes hold address/data for WR_SETUP cycles before a single
// wea strobe; reads wait RD_LAT cycles before sampling ddatain. All outputs
// come straight from flops, so every registered output is computed from the
// next state rather than the current one.
module dram_arb_ctrl #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int WR_SETUP  = 1,
    parameter int RD_LAT    = 2,
    parameter int PRIO_MODE = 0
) (
    input  logic            gclk,
    input  logic            rst_n,
    dram_arb_ctrl_if.slave  bus,
    output logic            wea_o,
    output logic            busy_o,
    output logic [AW-1:0]   daddr_o,
    output logic [DW-1:0]   ddataout_o,
    input  logic [DW-1:0]   ddatain_i
);

    typedef enum logic [2:0] {
        IDLE,
        WSETUP,
        WSTROBE,
        RWAIT,
        RDONE
    } state_t;

    localparam logic [3:0] WS_LOAD = 4'((WR_SETUP > 0) ? (WR_SETUP - 1) : 0);
    localparam logic [3:0] RL_LOAD = 4'((RD_LAT > 0) ? (RD_LAT - 1) : 0);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          lastRd_q, lastRd_d;
    logic          wea_q, wea_d;
    logic          wrAck_q, wrAck_d;
    logic          rdValid_q, rdValid_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] daddr_q, daddr_d;
    logic [DW-1:0] ddataout_q, ddataout_d;
    logic [DW-1:0] rdData_q, rdData_d;
    logic          selWr, selRd;

    // Pick which pending request wins; lastRd_q breaks ties in round-robin mode
    always_comb begin
        selWr = 1'b0;
        if (PRIO_MODE == 0) begin
            selWr = bus.wr_req;
        end else if (PRIO_MODE == 1) begin
            selWr = bus.wr_req & ~bus.rd_req;
        end else begin
            selWr = bus.wr_req & (~bus.rd_req | lastRd_q);
        end
        selRd = bus.rd_req & ~selWr;
    end

    // State and output registers, cleared together so a reset aborts any transaction
    always_ff @(posedge gclk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            lastRd_q   <= 1'b1;
            wea_q      <= 1'b0;
            wrAck_q    <= 1'b0;
            rdValid_q  <= 1'b0;
            busy_q     <= 1'b0;
            daddr_q    <= '0;
            ddataout_q <= '0;
            rdData_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lastRd_q   <= lastRd_d;
            wea_q      <= wea_d;
            wrAck_q    <= wrAck_d;
            rdValid_q  <= rdValid_d;
            busy_q     <= busy_d;
            daddr_q    <= daddr_d;
            ddataout_q <= ddataout_d;
            rdData_q   <= rdData_d;
        end
    end

    // Next-state sequencing; the latency counter reaching zero ends the wait states
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (selWr) begin
                    state_d = (WR_SETUP == 0) ? WSTROBE : WSETUP;
                end else if (selRd) begin
                    state_d = RWAIT;
                end
            end
            WSETUP:  if (cnt_q == 4'd0) state_d = WSTROBE;
            WSTROBE: state_d = IDLE;
            RWAIT:   if (cnt_q == 4'd0) state_d = RDONE;
            RDONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs, latches and counter
    always_comb begin
        cnt_d      = cnt_q;
        lastRd_d   = lastRd_q;
        daddr_d    = daddr_q;
        ddataout_d = ddataout_q;
        rdData_d   = rdData_q;
        wea_d      = (state_d == WSTROBE);
        wrAck_d    = (state_d == WSTROBE);
        rdValid_d  = (state_d == RDONE);
        busy_d     = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (selWr) begin
                    daddr_d    = bus.wr_addr;
                    ddataout_d = bus.wr_data;
                    cnt_d      = WS_LOAD;
                    lastRd_d   = 1'b0;
                end else if (selRd) begin
                    daddr_d  = bus.rd_addr;
                    cnt_d    = RL_LOAD;
                    lastRd_d = 1'b1;
                end
            end
            WSETUP: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            end
            RWAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdData_d = ddatain_i;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    assign wea_o        = wea_q;
    assign busy_o       = busy_q;
    assign daddr_o      = daddr_q;
    assign ddataout_o   = ddataout_q;
    assign bus.wr_ack   = wrAck_q;
    assign bus.rd_valid = rdValid_q;
    assign bus.rd_data  = rdData_q;

endmodule
